// File: rtl/raycast_pkg.sv
// raycast_pkg: shared state encoding, wall word layout and fixed-point constants
package raycast_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_DRAIN1 = 3'd2;
    localparam logic [2:0] S_DRAIN2 = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam int COORD_W  = 16;
    localparam int Y4_LSB   = 0;
    localparam int X4_LSB   = 16;
    localparam int Y3_LSB   = 32;
    localparam int X3_LSB   = 48;
    localparam int TEX_LSB  = 64;
    localparam int Q_FRAC   = 8;
    localparam int UV_MAX   = 64;
    localparam int UV_SHIFT = 6;
    function automatic int wall_w(input int tex_w);
        return TEX_LSB + tex_w;
    endfunction
endpackage

// File: rtl/rayCast.sv
// rayCast: combinational ray/segment intersection giving ray parameter and texture column
module rayCast
    import raycast_pkg::*;
(
    input  logic [15:0] x1_i,
    input  logic [15:0] y1_i,
    input  logic [15:0] x2_i,
    input  logic [15:0] y2_i,
    input  logic [15:0] x3_i,
    input  logic [15:0] y3_i,
    input  logic [15:0] x4_i,
    input  logic [15:0] y4_i,
    output logic        hit_o,
    output logic [15:0] dist_o,
    output logic [15:0] uv_o
);
    logic signed [35:0] dx, dy, ex, ey, wx, wy, den, tn, un, den_a, tn_a, un_a;
    logic [47:0] t_q, u_q;
    // Distance is the ray parameter t in units of the direction vector (x2-x1, y2-y1), Q8.8 saturated
    always_comb begin
        dx     = 36'($signed(x2_i)) - 36'($signed(x1_i));
        dy     = 36'($signed(y2_i)) - 36'($signed(y1_i));
        ex     = 36'($signed(x4_i)) - 36'($signed(x3_i));
        ey     = 36'($signed(y4_i)) - 36'($signed(y3_i));
        wx     = 36'($signed(x3_i)) - 36'($signed(x1_i));
        wy     = 36'($signed(y3_i)) - 36'($signed(y1_i));
        den    = dx * ey - dy * ex;
        tn     = wx * ey - wy * ex;
        un     = wx * dy - wy * dx;
        den_a  = den[35] ? -den : den;
        tn_a   = den[35] ? -tn : tn;
        un_a   = den[35] ? -un : un;
        hit_o  = (den_a != '0) && !tn_a[35] && !un_a[35] && (un_a <= den_a);
        t_q    = ({12'd0, tn_a} << Q_FRAC) / {12'd0, den_a};
        u_q    = ({12'd0, un_a} << UV_SHIFT) / {12'd0, den_a};
        dist_o = (|t_q[47:16]) ? 16'hFFFF : t_q[15:0];
        uv_o   = (|u_q[47:16]) ? 16'(UV_MAX) : u_q[15:0];
    end
endmodule

// File: rtl/ray_wall_scanner.sv
// ray_wall_scanner: streams walls from RAM through rayCast and keeps the nearest hit
module ray_wall_scanner
    import raycast_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int TEX_W = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [15:0]              ray_x1,
    input  logic [15:0]              ray_y1,
    input  logic [15:0]              ray_x2,
    input  logic [15:0]              ray_y2,
    input  logic [IDX_W-1:0]         wall_count,
    output logic                     wall_rd,
    output logic [IDX_W-1:0]         wall_addr,
    input  logic [wall_w(TEX_W)-1:0] wall_data,
    output logic                     busy,
    output logic                     done,
    output logic                     hit,
    output logic [15:0]              distance,
    output logic [15:0]              uv_x,
    output logic [TEX_W-1:0]         tex_id,
    output logic [IDX_W-1:0]         wall_index
);
    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, n_q, ridx_q, a_idx_q, best_idx_q, best_idx_d, res_idx_q;
    logic [15:0]      rx1_q, ry1_q, rx2_q, ry2_q;
    logic             go, rd_q, a_valid_q, a_hit_q, best_hit_q, best_hit_d, best_ld, res_ld, res_hit_q;
    logic [15:0]      a_dist_q, a_uv_q, best_dist_q, best_dist_d, best_uv_q, best_uv_d, res_dist_q, res_uv_q;
    logic [TEX_W-1:0] a_tex_q, best_tex_q, best_tex_d, res_tex_q;
    logic             rc_hit;
    logic [15:0]      rc_dist, rc_uv;

    rayCast u_cast (
        .x1_i   (rx1_q),
        .y1_i   (ry1_q),
        .x2_i   (rx2_q),
        .y2_i   (ry2_q),
        .x3_i   (wall_data[X3_LSB +: COORD_W]),
        .y3_i   (wall_data[Y3_LSB +: COORD_W]),
        .x4_i   (wall_data[X4_LSB +: COORD_W]),
        .y4_i   (wall_data[Y4_LSB +: COORD_W]),
        .hit_o  (rc_hit),
        .dist_o (rc_dist),
        .uv_o   (rc_uv)
    );

    assign wall_rd    = state_q == S_ISSUE;
    assign wall_addr  = wall_rd ? cnt_q : '0;
    assign busy       = state_q != S_IDLE;
    assign done       = state_q == S_DONE;
    assign hit        = res_hit_q;
    assign distance   = res_dist_q;
    assign uv_x       = res_uv_q;
    assign tex_id     = res_tex_q;
    assign wall_index = res_idx_q;

    // Next state, best-hit update (strict less-than keeps the lower index on ties) and result capture on entering DONE
    always_comb begin
        go      = (state_q == S_IDLE) && start;
        best_ld = a_valid_q && a_hit_q && (!best_hit_q || a_dist_q < best_dist_q);
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = go ? ((wall_count == '0) ? S_DONE : S_ISSUE) : S_IDLE;
            S_ISSUE:  state_d = (cnt_q == n_q - IDX_W'(1)) ? S_DRAIN1 : S_ISSUE;
            S_DRAIN1: state_d = S_DRAIN2;
            S_DRAIN2: state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
        best_hit_d  = go ? 1'b0 : (best_ld | best_hit_q);
        best_dist_d = go ? '0 : best_ld ? a_dist_q : best_dist_q;
        best_uv_d   = go ? '0 : best_ld ? a_uv_q : best_uv_q;
        best_tex_d  = go ? '0 : best_ld ? a_tex_q : best_tex_q;
        best_idx_d  = go ? '0 : best_ld ? a_idx_q : best_idx_q;
        res_ld      = (state_d == S_DONE) && (state_q != S_DONE);
    end

    // FSM, request latch and address counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            rx1_q   <= '0;
            ry1_q   <= '0;
            rx2_q   <= '0;
            ry2_q   <= '0;
        end else begin
            state_q <= state_d;
            if (go) begin
                cnt_q <= '0;
                n_q   <= wall_count;
                rx1_q <= ray_x1;
                ry1_q <= ray_y1;
                rx2_q <= ray_x2;
                ry2_q <= ray_y2;
            end else if (wall_rd) begin
                cnt_q <= cnt_q + IDX_W'(1);
            end
        end
    end

    // Read tracking and stage A: register the intersection of the wall returned this cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q      <= 1'b0;
            ridx_q    <= '0;
            a_valid_q <= 1'b0;
            a_hit_q   <= 1'b0;
            a_dist_q  <= '0;
            a_uv_q    <= '0;
            a_tex_q   <= '0;
            a_idx_q   <= '0;
        end else begin
            rd_q      <= wall_rd;
            ridx_q    <= wall_addr;
            a_valid_q <= rd_q;
            a_hit_q   <= rc_hit;
            a_dist_q  <= rc_dist;
            a_uv_q    <= rc_uv;
            a_tex_q   <= wall_data[TEX_LSB +: TEX_W];
            a_idx_q   <= ridx_q;
        end
    end

    // Stage B: running nearest hit of the current scan
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            best_hit_q  <= 1'b0;
            best_dist_q <= '0;
            best_uv_q   <= '0;
            best_tex_q  <= '0;
            best_idx_q  <= '0;
        end else begin
            best_hit_q  <= best_hit_d;
            best_dist_q <= best_dist_d;
            best_uv_q   <= best_uv_d;
            best_tex_q  <= best_tex_d;
            best_idx_q  <= best_idx_d;
        end
    end

    // Published results change only when a scan completes and hold until the next completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_hit_q  <= 1'b0;
            res_dist_q <= '0;
            res_uv_q   <= '0;
            res_tex_q  <= '0;
            res_idx_q  <= '0;
        end else if (res_ld) begin
            res_hit_q  <= best_hit_d;
            res_dist_q <= best_dist_d;
            res_uv_q   <= best_uv_d;
            res_tex_q  <= best_tex_d;
            res_idx_q  <= best_idx_d;
        end
    end
endmodule

// File: tb/tb_ray_wall_scanner.sv
// tb_ray_wall_scanner: directed and randomized scans against a geometric reference model
module tb_ray_wall_scanner;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] ray_x1 = '0, ray_y1 = '0, ray_x2 = '0, ray_y2 = '0;
    logic [7:0]  wall_count = '0;
    logic        wall_rd, busy, done, hit;
    logic [7:0]  wall_addr, wall_index;
    logic [67:0] wall_data = '0;
    logic [15:0] distance, uv_x;
    logic [3:0]  tex_id;

    logic [67:0] mem [256];
    logic [15:0] rx1, ry1, rx2, ry2;
    int checks = 0, errors = 0;
    int first_done, second_done, ndone, rd_cnt, addr_err, busy_cnt;
    logic        c_hit, e_hit;
    logic [15:0] c_dist, c_uv, e_dist, e_uv;
    logic [3:0]  c_tex, e_tex;
    logic [7:0]  c_idx, e_idx;

    ray_wall_scanner #(.IDX_W(8), .TEX_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .ray_x1(ray_x1), .ray_y1(ray_y1), .ray_x2(ray_x2), .ray_y2(ray_y2),
        .wall_count(wall_count), .wall_rd(wall_rd), .wall_addr(wall_addr), .wall_data(wall_data),
        .busy(busy), .done(done), .hit(hit), .distance(distance), .uv_x(uv_x),
        .tex_id(tex_id), .wall_index(wall_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (wall_rd) wall_data <= mem[wall_addr];

    function automatic logic [67:0] mk(input logic [3:0] t, input logic [15:0] a, b, c, d);
        return {t, a, b, c, d};
    endfunction

    function automatic longint s(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [15:0] rnd(input int r);
        return 16'($urandom_range(0, 2 * r)) - 16'(r);
    endfunction

    // Nearest intersection over the first n walls: solve origin + t*d = p3 + u*e, keep smallest t
    task automatic model(input int n);
        longint dx, dy, ex, ey, wx, wy, den, tn, un, d, u, best;
        logic [67:0] w;
        e_hit = 0; e_dist = 0; e_uv = 0; e_tex = 0; e_idx = 0; best = 0;
        for (int i = 0; i < n; i++) begin
            w  = mem[i];
            dx = s(rx2) - s(rx1);
            dy = s(ry2) - s(ry1);
            ex = s(w[31:16]) - s(w[63:48]);
            ey = s(w[15:0]) - s(w[47:32]);
            wx = s(w[63:48]) - s(rx1);
            wy = s(w[47:32]) - s(ry1);
            den = dx * ey - dy * ex;
            tn  = wx * ey - wy * ex;
            un  = wx * dy - wy * dx;
            if (den < 0) begin den = -den; tn = -tn; un = -un; end
            if (den != 0 && tn >= 0 && un >= 0 && un <= den) begin
                d = (tn * 256) / den;
                if (d > 65535) d = 65535;
                u = (un * 64) / den;
                if (!e_hit || d < best) begin
                    e_hit = 1; best = d; e_dist = 16'(d); e_uv = 16'(u); e_tex = w[67:64]; e_idx = 8'(i);
                end
            end
        end
    endtask

    // Issues start in cycle 0 and watches `budget` cycles; the ray/count ports are scrambled afterwards unless hold
    task automatic run_scan(input int n, input int budget, input int pulse_at, input bit hold);
        first_done = -1; second_done = -1; ndone = 0; rd_cnt = 0; addr_err = 0; busy_cnt = 0;
        @(negedge clk);
        wall_count = 8'(n); ray_x1 = rx1; ray_y1 = ry1; ray_x2 = rx2; ray_y2 = ry2; start = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (wall_rd) begin
                rd_cnt++;
                if (!hold && (wall_addr !== 8'(c - 1) || c > n)) addr_err++;
            end
            if (busy) busy_cnt++;
            if (done) begin
                if (ndone == 0) begin
                    first_done = c; c_hit = hit; c_dist = distance; c_uv = uv_x; c_tex = tex_id; c_idx = wall_index;
                end else if (ndone == 1) second_done = c;
                ndone++;
            end
            start = hold || (c == pulse_at);
            if (!hold) begin
                ray_x1 = 16'($urandom); ray_y1 = 16'($urandom); ray_x2 = 16'($urandom); ray_y2 = 16'($urandom);
                wall_count = 8'($urandom);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, wall_rd, hit} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, wall_rd, hit});
        end
        checks++;
        if ({wall_addr, distance, uv_x, tex_id, wall_index} !== '0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {wall_addr, distance, uv_x, tex_id, wall_index});
        end
    endtask

    task automatic test_single_hit;
        mem[0] = mk(4'd3, 16'h0400, 16'hFE00, 16'h0400, 16'h0200);
        rx1 = 0; ry1 = 0; rx2 = 16'h0100; ry2 = 0;
        run_scan(1, 10, -1, 1'b0);
        checks++;
        if (first_done !== 4 || ndone !== 1) begin errors++; $display("FAIL single_done: got cycle %0d count %0d expected 4/1", first_done, ndone); end
        checks++;
        if (c_hit !== 1'b1) begin errors++; $display("FAIL single_hit: got %b expected 1", c_hit); end
        checks++;
        if (c_dist !== 16'h0400) begin errors++; $display("FAIL single_dist: got %h expected 0400", c_dist); end
        checks++;
        if (c_uv !== 16'd32) begin errors++; $display("FAIL single_uv: got %0d expected 32", c_uv); end
        checks++;
        if ({c_tex, c_idx} !== {4'd3, 8'd0}) begin errors++; $display("FAIL single_tex_idx: got %h/%h expected 3/0", c_tex, c_idx); end
        checks++;
        if (rd_cnt !== 1 || addr_err !== 0) begin errors++; $display("FAIL single_reads: got %0d reads %0d bad expected 1/0", rd_cnt, addr_err); end
        checks++;
        if (busy_cnt !== 4) begin errors++; $display("FAIL single_busy: got %0d cycles expected 4", busy_cnt); end
        checks++;
        if (distance !== 16'h0400 || hit !== 1'b1) begin errors++; $display("FAIL single_hold: got %h/%b expected 0400/1", distance, hit); end
    endtask

    task automatic test_nearest;
        mem[0] = mk(4'd1, 16'h0400, 16'hFE00, 16'h0400, 16'h0200);
        mem[1] = mk(4'd2, 16'h0200, 16'hFE00, 16'h0200, 16'h0200);
        rx1 = 0; ry1 = 0; rx2 = 16'h0100; ry2 = 0;
        run_scan(2, 10, -1, 1'b0);
        checks++;
        if ({c_dist, c_idx, c_tex} !== {16'h0200, 8'd1, 4'd2} || first_done !== 5) begin
            errors++; $display("FAIL nearest: got dist %h idx %0d tex %0d cycle %0d expected 0200/1/2/5", c_dist, c_idx, c_tex, first_done);
        end
        mem[0] = mk(4'd2, 16'h0200, 16'hFE00, 16'h0200, 16'h0200);
        mem[1] = mk(4'd1, 16'h0400, 16'hFE00, 16'h0400, 16'h0200);
        run_scan(2, 10, -1, 1'b0);
        checks++;
        if ({c_dist, c_idx, c_tex} !== {16'h0200, 8'd0, 4'd2}) begin
            errors++; $display("FAIL nearest_swap: got dist %h idx %0d tex %0d expected 0200/0/2", c_dist, c_idx, c_tex);
        end
    endtask

    task automatic test_tie;
        mem[0] = mk(4'd5, 16'h0300, 16'hFE00, 16'h0300, 16'h0200);
        mem[1] = mk(4'd5, 16'h0300, 16'hFE00, 16'h0300, 16'h0200);
        rx1 = 0; ry1 = 0; rx2 = 16'h0100; ry2 = 0;
        run_scan(2, 10, -1, 1'b0);
        checks++;
        if (c_idx !== 8'd0 || c_dist !== 16'h0300 || first_done !== 5) begin
            errors++; $display("FAIL tie: got idx %0d dist %h cycle %0d expected 0/0300/5", c_idx, c_dist, first_done);
        end
    endtask

    task automatic test_no_hit;
        mem[0] = mk(4'd7, 16'hFC00, 16'hFE00, 16'hFC00, 16'h0200);
        rx1 = 0; ry1 = 0; rx2 = 16'h0100; ry2 = 0;
        run_scan(1, 10, -1, 1'b0);
        checks++;
        if (c_hit !== 1'b0 || {c_dist, c_uv, c_tex, c_idx} !== '0 || first_done !== 4) begin
            errors++; $display("FAIL no_hit: got hit %b data %h cycle %0d expected 0/0/4", c_hit, {c_dist, c_uv, c_tex, c_idx}, first_done);
        end
    endtask

    task automatic test_empty;
        run_scan(0, 6, -1, 1'b0);
        checks++;
        if (first_done !== 1 || ndone !== 1 || rd_cnt !== 0 || c_hit !== 1'b0) begin
            errors++; $display("FAIL empty: got cycle %0d dones %0d reads %0d hit %b expected 1/1/0/0", first_done, ndone, rd_cnt, c_hit);
        end
    endtask

    task automatic test_start_ignored;
        for (int i = 0; i < 6; i++) mem[i] = mk(4'($urandom), rnd(16'h1000), rnd(16'h1000), rnd(16'h1000), rnd(16'h1000));
        mem[2] = mk(4'd9, 16'h0500, 16'hF000, 16'h0500, 16'h1000);
        rx1 = 0; ry1 = 0; rx2 = 16'h0100; ry2 = 16'h0020;
        model(6);
        run_scan(6, 16, 2, 1'b0);
        checks++;
        if (ndone !== 1 || first_done !== 9) begin errors++; $display("FAIL ignore_done: got %0d dones first %0d expected 1/9", ndone, first_done); end
        checks++;
        if ({c_hit, c_dist, c_uv, c_tex, c_idx} !== {e_hit, e_dist, e_uv, e_tex, e_idx}) begin
            errors++; $display("FAIL ignore_result: got %h expected %h", {c_hit, c_dist, c_uv, c_tex, c_idx}, {e_hit, e_dist, e_uv, e_tex, e_idx});
        end
    endtask

    task automatic test_back_to_back;
        mem[0] = mk(4'd1, 16'h0400, 16'hFE00, 16'h0400, 16'h0200);
        mem[1] = mk(4'd2, 16'h0200, 16'hFE00, 16'h0200, 16'h0200);
        rx1 = 0; ry1 = 0; rx2 = 16'h0100; ry2 = 0;
        run_scan(2, 13, -1, 1'b1);
        checks++;
        if (ndone !== 2 || first_done !== 5 || second_done !== 11) begin
            errors++; $display("FAIL back_to_back: got %0d dones at %0d,%0d expected 2 at 5,11", ndone, first_done, second_done);
        end
        checks++;
        if (distance !== 16'h0200 || wall_index !== 8'd1) begin
            errors++; $display("FAIL back_to_back_result: got %h/%0d expected 0200/1", distance, wall_index);
        end
    endtask

    task automatic test_reset_mid;
        int nd;
        for (int i = 0; i < 10; i++) mem[i] = mk(4'(i), 16'((10 - i) * 256), 16'hFE00, 16'((10 - i) * 256), 16'h0200);
        rx1 = 0; ry1 = 0; rx2 = 16'h0100; ry2 = 0;
        @(negedge clk);
        wall_count = 8'd10; ray_x1 = rx1; ray_y1 = ry1; ray_x2 = rx2; ray_y2 = ry2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, wall_rd, hit} !== 4'b0) begin
            errors++; $display("FAIL midreset_ctrl: got %b expected 0000", {busy, done, wall_rd, hit});
        end
        checks++;
        if ({wall_addr, distance, uv_x, tex_id, wall_index} !== '0) begin
            errors++; $display("FAIL midreset_data: got %h expected 0", {wall_addr, distance, uv_x, tex_id, wall_index});
        end
        nd = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            reset_n = 1'b1;
            if (done) nd++;
        end
        checks++;
        if (nd !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses expected 0", nd); end
        run_scan(10, 16, -1, 1'b0);
        checks++;
        if (first_done !== 13 || c_idx !== 8'd9 || c_dist !== 16'h0100 || c_tex !== 4'd9) begin
            errors++; $display("FAIL midreset_rescan: got cycle %0d idx %0d dist %h tex %0d expected 13/9/0100/9", first_done, c_idx, c_dist, c_tex);
        end
    endtask

    task automatic test_random;
        int n;
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) mem[i] = mk(4'($urandom), rnd(16'h1000), rnd(16'h1000), rnd(16'h1000), rnd(16'h1000));
            rx1 = rnd(16'h0400); ry1 = rnd(16'h0400); rx2 = rnd(16'h1000); ry2 = rnd(16'h1000);
            model(n);
            run_scan(n, n + 8, -1, 1'b0);
            checks++;
            if (first_done !== n + 3 || ndone !== 1) begin
                errors++; $display("FAIL rand_done[%0d]: got cycle %0d count %0d expected %0d/1", it, first_done, ndone, n + 3);
            end
            checks++;
            if ({c_hit, c_dist, c_uv, c_tex, c_idx} !== {e_hit, e_dist, e_uv, e_tex, e_idx}) begin
                errors++; $display("FAIL rand_result[%0d]: got %h expected %h", it, {c_hit, c_dist, c_uv, c_tex, c_idx}, {e_hit, e_dist, e_uv, e_tex, e_idx});
            end
            checks++;
            if (rd_cnt !== n || addr_err !== 0 || busy_cnt !== n + 3) begin
                errors++; $display("FAIL rand_issue[%0d]: got reads %0d bad %0d busy %0d expected %0d/0/%0d", it, rd_cnt, addr_err, busy_cnt, n, n + 3);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset;
        test_single_hit;
        test_nearest;
        test_tie;
        test_no_hit;
        test_empty;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
